// File: rtl/debouncer_pkg.sv
// Shared state encoding and default settling length for the button debouncer.
package debouncer_pkg;

  localparam int unsigned STABLE_CYCLES_DEFAULT = 4;

  typedef enum logic [1:0] {
    STATE_STABLE_LOW  = 2'b00,
    STATE_WAIT_HIGH   = 2'b01,
    STATE_STABLE_HIGH = 2'b10,
    STATE_WAIT_LOW    = 2'b11
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchronizer for an asynchronous single-bit input; both stages reset to 0.
module sync_2ff (
  input  logic i_w_clk,
  input  logic i_w_reset,
  input  logic i_w_d,
  output logic o_w_q
);

  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_w_d;
      r_sync2 <= r_sync1;
    end
  end

  assign o_w_q = r_sync2;

endmodule

// File: rtl/button_debouncer.sv
// Debounces a bouncing button into a stable level plus one-cycle rise/fall pulses.
module button_debouncer
  import debouncer_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
  parameter int unsigned CNT_WIDTH     = 3
) (
  input  logic i_w_clk,
  input  logic i_w_reset,
  input  logic i_w_in,
  output logic o_w_level,
  output logic o_w_rise,
  output logic o_w_fall
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic                 w_s;
  state_e               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_rise;
  logic                 r_fall;

  sync_2ff u_sync (
    .i_w_clk   (i_w_clk),
    .i_w_reset (i_w_reset),
    .i_w_d     (i_w_in),
    .o_w_q     (w_s)
  );

  // r_cnt counts consecutive samples disagreeing with the current level; capped at CNT_LAST.
  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      r_state <= STATE_STABLE_LOW;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        STATE_STABLE_LOW: begin
          if (w_s) begin
            r_state <= STATE_WAIT_HIGH;
            r_cnt   <= CNT_ONE;
          end
        end
        STATE_WAIT_HIGH: begin
          if (!w_s) begin
            r_state <= STATE_STABLE_LOW;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= STATE_STABLE_HIGH;
            r_cnt   <= '0;
            r_rise  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        STATE_STABLE_HIGH: begin
          if (!w_s) begin
            r_state <= STATE_WAIT_LOW;
            r_cnt   <= CNT_ONE;
          end
        end
        STATE_WAIT_LOW: begin
          if (w_s) begin
            r_state <= STATE_STABLE_HIGH;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= STATE_STABLE_LOW;
            r_cnt   <= '0;
            r_fall  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= STATE_STABLE_LOW;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_w_level = (r_state == STATE_STABLE_HIGH) || (r_state == STATE_WAIT_LOW);
  assign o_w_rise  = r_rise;
  assign o_w_fall  = r_fall;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed-vector bench for button_debouncer with STABLE_CYCLES=4; edges numbered from reset release.
module tb_button_debouncer;

  logic clk = 1'b0;
  logic rst;
  logic din;
  logic level;
  logic rise;
  logic fall;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  button_debouncer #(
    .STABLE_CYCLES (4),
    .CNT_WIDTH     (3)
  ) dut (
    .i_w_clk   (clk),
    .i_w_reset (rst),
    .i_w_in    (din),
    .o_w_level (level),
    .o_w_rise  (rise),
    .o_w_fall  (fall)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Input value driven just before edge e.
  function automatic logic stim_in(input int scn, input int e);
    case (scn)
      2: return (e >= 10) && (e < 30);
      3: begin
        case (e)
          10: return 1'b1;
          11: return 1'b0;
          12: return 1'b1;
          13: return 1'b1;
          14: return 1'b0;
          default: return e >= 15;
        endcase
      end
      4: return ((e >= 10) && (e <= 12)) || ((e >= 30) && (e <= 33));
      5: return e >= 10;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic stim_rst(input int scn, input int e);
    return (scn == 5) && (e == 13);
  endfunction

  function automatic logic exp_rise(input int scn, input int e);
    case (scn)
      2: return e == 15;
      3: return e == 20;
      4: return e == 35;
      5: return e == 19;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic exp_fall(input int scn, input int e);
    case (scn)
      2: return e == 35;
      4: return e == 39;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic exp_level(input int scn, input int e);
    case (scn)
      2: return (e >= 15) && (e < 35);
      3: return e >= 20;
      4: return (e >= 35) && (e < 39);
      5: return e >= 19;
      default: return 1'b0;
    endcase
  endfunction

  task automatic do_reset(input int scn);
    rst = 1'b1;
    din = 1'b0;
    tick();
    tick();
    check_eq($sformatf("s%0d reset level", scn), int'(level), 0);
    check_eq($sformatf("s%0d reset rise", scn), int'(rise), 0);
    check_eq($sformatf("s%0d reset fall", scn), int'(fall), 0);
    rst = 1'b0;
  endtask

  task automatic run_scn(input int scn, input int last_edge);
    do_reset(scn);
    for (int e = 1; e <= last_edge; e++) begin
      din = stim_in(scn, e);
      rst = stim_rst(scn, e);
      tick();
      check_eq($sformatf("s%0d e%0d level", scn, e), int'(level), int'(exp_level(scn, e)));
      check_eq($sformatf("s%0d e%0d rise", scn, e), int'(rise), int'(exp_rise(scn, e)));
      check_eq($sformatf("s%0d e%0d fall", scn, e), int'(fall), int'(exp_fall(scn, e)));
    end
  endtask

  initial begin
    rst = 1'b1;
    din = 1'b0;
    run_scn(1, 20);  // idle low
    run_scn(2, 40);  // clean press then release
    run_scn(3, 30);  // bouncing press
    run_scn(4, 45);  // 3-cycle glitch, then 4-cycle pulse
    run_scn(5, 25);  // reset during WAIT_HIGH
    run_scn(3, 30);  // reset from level high
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
